// File: rtl/ora_misr.sv
// ora_misr - output response analyser for the LBIST chain.
//
// Folds every valid CUT response word into a multiple-input signature
// register (MISR). The pattern generator's END flag closes the session; one
// cycle later the final signature is compared against GOLDEN and DONE/PASS
// are raised for the BIST controller.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   START      single-cycle pulse, opens a session from IDLE or DONE
//   VALID      RESPONSE is to be compressed this cycle (RUN only)
//   RESPONSE   CUT output word, BITS wide
//   END        last-pattern flag from the pattern generator (RUN only)
//   SIGNATURE  current MISR contents
//   COUNT      responses compressed this session, saturating
//   BUSY       high in RUN and CHECK
//   DONE       high in DONE
//   PASS       signature matched GOLDEN, meaningful while DONE is high

module ora_misr #(
    parameter int unsigned       BITS   = 4,
    parameter logic [BITS-1:0]   POLY   = 4'b0011,
    parameter logic [BITS-1:0]   SEED   = '0,
    parameter logic [BITS-1:0]   GOLDEN = '0,
    parameter int unsigned       CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             START,
    input  logic             VALID,
    input  logic [BITS-1:0]  RESPONSE,
    input  logic             END,
    output logic [BITS-1:0]  SIGNATURE,
    output logic [CNT_W-1:0] COUNT,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StCheck,
        StDone
    } state_t;

    state_t           r_state;
    logic [BITS-1:0]  r_sig;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;

    logic             w_fb;
    logic [BITS-1:0]  w_next_sig;
    logic [CNT_W-1:0] w_cnt_inc;

    // One MISR step: shift up, feed the top bit back into stage 0 and every
    // stage whose POLY bit is set, and XOR the response word in parallel.
    always_comb begin
        w_next_sig    = '0;
        w_fb          = r_sig[BITS-1];
        w_next_sig[0] = w_fb ^ RESPONSE[0];
        for (int i = 1; i < int'(BITS); i++) begin
            w_next_sig[i] = r_sig[i-1] ^ (POLY[i] & w_fb) ^ RESPONSE[i];
        end
    end

    // Counter sticks at all-ones rather than wrapping.
    always_comb begin
        w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_sig   <= SEED;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    // VALID and END are ignored here, START alone matters.
                    if (START) begin
                        r_sig   <= SEED;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= StRun;
                    end
                end
                StRun: begin
                    // A response coincident with END is still compressed.
                    if (VALID) begin
                        r_sig <= w_next_sig;
                        r_cnt <= w_cnt_inc;
                    end
                    if (END) begin
                        r_state <= StCheck;
                    end
                end
                StCheck: begin
                    r_pass  <= (r_sig == GOLDEN);
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= StDone;
                end
                StDone: begin
                    if (START) begin
                        r_done  <= 1'b0;
                        r_pass  <= 1'b0;
                        r_sig   <= SEED;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= StRun;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign SIGNATURE = r_sig;
    assign COUNT     = r_cnt;
    assign BUSY      = r_busy;
    assign DONE      = r_done;
    assign PASS      = r_pass;

endmodule

// File: tb/tb_ora_misr.sv
// Bench for ora_misr. Two instances share the stimulus: u_dut (16-bit
// counter, GOLDEN=4'h4) and u_sat (2-bit counter, GOLDEN=0). A behavioural
// model treats the signature as a GF(2) polynomial multiplied by x modulo
// x^4+x+1 plus the response, and is compared with both instances every cycle.

module tb_ora_misr;

    localparam logic [3:0] Seed    = 4'h0;
    localparam logic [3:0] GoldDut = 4'h4;
    localparam logic [3:0] GoldSat = 4'h0;

    logic       clk;
    logic       rst;
    logic       start_s;
    logic       valid_s;
    logic [3:0] resp_s;
    logic       end_s;

    logic [3:0]  sig_d, sig_s;
    logic [15:0] cnt_d;
    logic [1:0]  cnt_s;
    logic        busy_d, busy_s, done_d, done_s, pass_d, pass_s;

    int total;
    int bad;

    ora_misr #(
        .BITS   (4),
        .POLY   (4'b0011),
        .SEED   (Seed),
        .GOLDEN (GoldDut),
        .CNT_W  (16)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .START     (start_s),
        .VALID     (valid_s),
        .RESPONSE  (resp_s),
        .END       (end_s),
        .SIGNATURE (sig_d),
        .COUNT     (cnt_d),
        .BUSY      (busy_d),
        .DONE      (done_d),
        .PASS      (pass_d)
    );

    ora_misr #(
        .BITS   (4),
        .POLY   (4'b0011),
        .SEED   (Seed),
        .GOLDEN (GoldSat),
        .CNT_W  (2)
    ) u_sat (
        .clk       (clk),
        .rst       (rst),
        .START     (start_s),
        .VALID     (valid_s),
        .RESPONSE  (resp_s),
        .END       (end_s),
        .SIGNATURE (sig_s),
        .COUNT     (cnt_s),
        .BUSY      (busy_s),
        .DONE      (done_s),
        .PASS      (pass_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 collecting, 2 judging, 3 finished
    int          m_phase;
    logic [3:0]  m_sig;
    int unsigned m_n;
    logic        m_done;
    logic        m_pass_d;
    logic        m_pass_s;
    logic        m_live;

    // sig*x mod (x^4+x+1), then add the response polynomial
    function automatic logic [3:0] misr_step(input logic [3:0] s, input logic [3:0] r);
        logic [4:0] p;
        p = {s, 1'b0};
        if (p[4]) p = p ^ 5'b10011;
        return p[3:0] ^ r;
    endfunction

    initial begin
        m_live   = 1'b0;
        m_phase  = 0;
        m_sig    = Seed;
        m_n      = 0;
        m_done   = 1'b0;
        m_pass_d = 1'b0;
        m_pass_s = 1'b0;
    end

    always @(posedge clk) begin
        if (rst) begin
            m_live   = 1'b1;
            m_phase  = 0;
            m_sig    = Seed;
            m_n      = 0;
            m_done   = 1'b0;
            m_pass_d = 1'b0;
            m_pass_s = 1'b0;
        end else if (m_phase == 0) begin
            if (start_s) begin
                m_sig   = Seed;
                m_n     = 0;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (valid_s) begin
                m_sig = misr_step(m_sig, resp_s);
                m_n   = m_n + 1;
            end
            if (end_s) m_phase = 2;
        end else if (m_phase == 2) begin
            m_pass_d = (m_sig == GoldDut);
            m_pass_s = (m_sig == GoldSat);
            m_done   = 1'b1;
            m_phase  = 3;
        end else begin
            if (start_s) begin
                m_done   = 1'b0;
                m_pass_d = 1'b0;
                m_pass_s = 1'b0;
                m_sig    = Seed;
                m_n      = 0;
                m_phase  = 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (m_live) begin
            logic exp_busy;
            exp_busy = (m_phase == 1) || (m_phase == 2);
            chk("sig_d",  32'(sig_d),  32'(m_sig));
            chk("sig_s",  32'(sig_s),  32'(m_sig));
            chk("cnt_d",  32'(cnt_d),  (m_n > 65535) ? 32'd65535 : 32'(m_n));
            chk("cnt_s",  32'(cnt_s),  (m_n > 3) ? 32'd3 : 32'(m_n));
            chk("busy_d", 32'(busy_d), 32'(exp_busy));
            chk("busy_s", 32'(busy_s), 32'(exp_busy));
            chk("done_d", 32'(done_d), 32'(m_done));
            chk("done_s", 32'(done_s), 32'(m_done));
            if (m_done) begin
                chk("pass_d", 32'(pass_d), 32'(m_pass_d));
                chk("pass_s", 32'(pass_s), 32'(m_pass_s));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic s, input logic v, input logic [3:0] r, input logic e);
        start_s = s;
        valid_s = v;
        resp_s  = r;
        end_s   = e;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst     = 1'b1;
        start_s = 1'b0;
        valid_s = 1'b0;
        resp_s  = 4'h0;
        end_s   = 1'b0;

        // Reset values
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        chk("rst_sig",  32'(sig_d),  32'h0);
        chk("rst_cnt",  32'(cnt_d),  32'h0);
        chk("rst_busy", 32'(busy_d), 32'h0);
        chk("rst_done", 32'(done_d), 32'h0);
        chk("rst_pass", 32'(pass_d), 32'h0);
        rst = 1'b0;
        drive(0, 1, 4'h7, 1);  // ignored in IDLE
        chk("idle_ign_sig",  32'(sig_d),  32'h0);
        chk("idle_ign_busy", 32'(busy_d), 32'h0);

        // Basic compression: 1,2,4 -> 4'h4
        drive(1, 0, 0, 0);
        drive(0, 1, 4'h1, 0);
        drive(0, 1, 4'h2, 0);
        drive(0, 1, 4'h4, 1);
        chk("s2_sig",  32'(sig_d),  32'h4);
        chk("s2_cnt",  32'(cnt_d),  32'h3);
        chk("s2_busy_check", 32'(busy_d), 32'h1);
        chk("s2_done_early", 32'(done_d), 32'h0);
        drive(0, 0, 0, 0);
        chk("s2_done",   32'(done_d), 32'h1);
        chk("s2_pass",   32'(pass_d), 32'h1);
        chk("s2_pass_s", 32'(pass_s), 32'h0);
        drive(0, 1, 4'hF, 1);  // DONE holds
        chk("s2_hold_sig",  32'(sig_d),  32'h4);
        chk("s2_hold_done", 32'(done_d), 32'h1);

        // Feedback path: 8,0 -> 4'h3; restart from DONE
        drive(1, 0, 0, 0);
        chk("s3_done_drop", 32'(done_d), 32'h0);
        chk("s3_reseed",    32'(sig_d),  32'h0);
        drive(0, 1, 4'h8, 0);
        drive(0, 1, 4'h0, 1);
        chk("s3_sig", 32'(sig_d), 32'h3);
        chk("s3_cnt", 32'(cnt_d), 32'h2);
        drive(0, 0, 0, 0);
        chk("s3_done",   32'(done_s), 32'h1);
        chk("s3_pass_s", 32'(pass_s), 32'h0);
        chk("s3_pass_d", 32'(pass_d), 32'h0);

        // Gaps and END on a VALID=0 cycle
        drive(1, 0, 0, 0);
        drive(0, 1, 4'h1, 0);
        drive(0, 0, 4'hF, 0);
        drive(0, 1, 4'h2, 0);
        drive(0, 0, 4'hB, 0);
        drive(0, 1, 4'h4, 0);
        drive(0, 0, 4'h9, 1);
        chk("s4_sig", 32'(sig_d), 32'h4);
        chk("s4_cnt", 32'(cnt_d), 32'h3);
        drive(0, 0, 0, 0);
        chk("s4_pass", 32'(pass_d), 32'h1);

        // Reset mid-RUN discards the session
        drive(1, 0, 0, 0);
        drive(0, 1, 4'h1, 0);
        drive(0, 1, 4'h2, 0);
        rst = 1'b1;
        drive(0, 1, 4'h4, 1);
        rst = 1'b0;
        chk("s5_rst_sig",  32'(sig_d),  32'h0);
        chk("s5_rst_cnt",  32'(cnt_d),  32'h0);
        chk("s5_rst_busy", 32'(busy_d), 32'h0);
        drive(0, 0, 0, 0);
        chk("s5_no_done", 32'(done_d), 32'h0);
        // START and END together in IDLE: START wins
        drive(1, 0, 0, 1);
        drive(0, 0, 0, 0);
        chk("s5_startend_busy", 32'(busy_d), 32'h1);
        drive(0, 1, 4'h1, 0);
        drive(0, 1, 4'h2, 0);
        drive(0, 1, 4'h4, 1);
        drive(0, 0, 0, 0);
        chk("s5_rerun_sig",  32'(sig_d),  32'h4);
        chk("s5_rerun_pass", 32'(pass_d), 32'h1);

        // Saturation and START ignored in RUN
        drive(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 1, 4'(i + 3), 0);
        chk("s6_cnt_sat", 32'(cnt_s), 32'h3);
        chk("s6_cnt_d",   32'(cnt_d), 32'h5);
        drive(1, 0, 0, 0);
        chk("s6_start_run_cnt", 32'(cnt_d), 32'h5);
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 0);

        // Randomised traffic checked by the model every cycle
        for (int n = 0; n < 4000; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 11) == 0, $urandom_range(0, 1) == 1,
                  4'($urandom_range(0, 15)), $urandom_range(0, 9) == 0);
        end
        rst = 1'b0;
        drive(0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
